// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch front end.
//   fetch_state_e : fetch sequencer states (HOLD after reset, RUN, DRAIN
//                   while stale responses of a redirected stream return)
//   PC_INCR       : byte stride between consecutive instruction fetches
//   PC_ALIGN_MASK : mask applied to the two low bits of a redirect target
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [2:0] PC_INCR       = 3'd4;
   localparam logic [1:0] PC_ALIGN_MASK = 2'b00;

endpackage : mips_fetch_pkg

// File: rtl/mips_fetch_checker.sv
// Run-time invariants of the fetch unit.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (checks idle in reset)
//   i_outstanding  : requests granted but not yet answered
//   i_fifo_count   : buffered instructions
//   i_rvalid       : raw response strobe from instruction memory
//   i_push/i_pop/i_full : FIFO write/read strobes and full flag
module mips_fetch_checker #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input logic          clk,
   input logic          rst_n,
   input logic [CW-1:0] i_outstanding,
   input logic [CW-1:0] i_fifo_count,
   input logic          i_rvalid,
   input logic          i_push,
   input logic          i_pop,
   input logic          i_full
);

   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   logic [CW:0] w_inflight;
   assign w_inflight = {1'b0, i_outstanding} + {1'b0, i_fifo_count};

   // Credit invariant, overflow and unsolicited-response checks.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (w_inflight <= DEPTH_L)
            else $error("fetch credit exceeded: %0d in flight", w_inflight);
         assert (!(i_push && i_full && !i_pop))
            else $error("instruction buffer overflow");
         assert (!(i_rvalid && (i_outstanding == CW'(0))))
            else $error("rvalid with no outstanding request");
      end
   end

endmodule : mips_fetch_checker

// File: rtl/mips_fetch_fifo.sv
// Instruction buffer: synchronous FIFO holding {pc, instruction} pairs.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_push / i_data   : write one entry (accepted when not full, or when
//                       a pop happens in the same cycle)
//   i_pop             : drop the head entry (ignored when empty)
//   i_flush           : discard every entry; has priority over push/pop
//   o_head            : head entry (storage resets to RST_VAL)
//   o_count/o_full/o_empty : occupancy status
module mips_fetch_fifo #(
   parameter int unsigned         DEPTH   = 4,
   parameter int unsigned         WIDTH   = 64,
   parameter logic [WIDTH-1:0]    RST_VAL = '0,
   localparam int unsigned        AW      = $clog2(DEPTH),
   localparam int unsigned        CW      = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_head,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_count == CW'(0));
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Pop is evaluated first so a push into a full FIFO is legal when the head leaves.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= RST_VAL;
         end
         r_wr_ptr <= AW'(0);
         r_rd_ptr <= AW'(0);
         r_count  <= CW'(0);
      end else if (i_flush) begin
         r_wr_ptr <= AW'(0);
         r_rd_ptr <= AW'(0);
         r_count  <= CW'(0);
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule : mips_fetch_fifo

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined requests
// to an instruction memory (req/gnt/rvalid), buffers returned words with
// their PCs and hands them to decode over valid/ready. A redirect flushes
// the buffer and discards responses still in flight from the old stream.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   imem_req_o / imem_addr_o   : request strobe and address (= fetch PC)
//   imem_gnt_i                 : request accepted (counted only with req)
//   imem_rvalid_i/imem_rdata_i : in-order read response
//   redirect_i / redirect_pc_i : taken branch/jump and its target
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : decode handshake
//   curr_pc_o                  : current fetch PC for trace
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IBUF_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] curr_pc_o
);

   localparam int unsigned    CW      = $clog2(IBUF_DEPTH) + 1;
   localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_PC);
   localparam logic [CW:0]    DEPTH_L = (CW+1)'(IBUF_DEPTH);

   fetch_state_e     r_state;
   fetch_state_e     w_state_nxt;
   logic [XLEN-1:0]  r_fetch_pc;
   logic [XLEN-1:0]  r_resp_pc;
   logic [CW-1:0]    r_outstanding;
   logic [CW-1:0]    r_discard;

   logic [XLEN-1:0]  w_redir_pc;
   logic [XLEN-1:0]  w_incr;
   logic [CW:0]      w_inflight;
   logic             w_req;
   logic             w_gnt;
   logic             w_rv;
   logic             w_drop;
   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_out_nxt;
   logic [CW-1:0]    w_discard_nxt;
   logic [CW-1:0]    w_fifo_count;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [32+XLEN-1:0] w_fifo_head;

   assign w_redir_pc = {redirect_pc_i[XLEN-1:2], redirect_pc_i[1:0] & PC_ALIGN_MASK};
   assign w_incr     = XLEN'(PC_INCR);

   // Credit check: every granted request already owns a buffer slot.
   assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
   assign w_req      = (r_state != ST_HOLD) && (w_inflight < DEPTH_L);
   assign w_gnt      = w_req && imem_gnt_i;
   // A response with nothing outstanding (late, across a reset) is ignored.
   assign w_rv       = imem_rvalid_i && (r_outstanding != CW'(0));
   assign w_drop     = w_rv && (r_discard != CW'(0));
   assign w_push     = w_rv && !w_drop && !redirect_i;
   assign w_pop      = instr_valid_o && instr_ready_i && !redirect_i;
   assign w_out_nxt  = r_outstanding + CW'(w_gnt) - CW'(w_rv);

   // On redirect every request still in flight (including this cycle's grant) is stale.
   always_comb begin
      w_discard_nxt = r_discard;
      if (redirect_i) begin
         w_discard_nxt = w_out_nxt;
      end else if (w_drop) begin
         w_discard_nxt = r_discard - CW'(1);
      end else begin
         w_discard_nxt = r_discard;
      end
   end

   // Next-state logic of the fetch sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_HOLD: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_i && (w_out_nxt != CW'(0))) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (w_discard_nxt == CW'(0)) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: begin
            w_state_nxt = ST_HOLD;
         end
      endcase
   end

   // State, PCs and request/discard counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_HOLD;
         r_fetch_pc    <= RST_PC;
         r_resp_pc     <= RST_PC;
         r_outstanding <= CW'(0);
         r_discard     <= CW'(0);
      end else begin
         r_state       <= w_state_nxt;
         r_outstanding <= w_out_nxt;
         r_discard     <= w_discard_nxt;
         if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
         end else begin
            if (w_gnt) begin
               r_fetch_pc <= r_fetch_pc + w_incr;
            end
            if (w_push) begin
               r_resp_pc <= r_resp_pc + w_incr;
            end
         end
      end
   end

   mips_fetch_fifo #(
      .DEPTH   (IBUF_DEPTH),
      .WIDTH   (32 + XLEN),
      .RST_VAL ({RST_PC, 32'h0000_0000})
   ) u_ibuf (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_data  ({r_resp_pc, imem_rdata_i}),
      .i_pop   (w_pop),
      .i_flush (redirect_i),
      .o_head  (w_fifo_head),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   mips_fetch_checker #(
      .DEPTH (IBUF_DEPTH)
   ) u_chk (
      .clk           (clk),
      .rst_n         (reset),
      .i_outstanding (r_outstanding),
      .i_fifo_count  (w_fifo_count),
      .i_rvalid      (imem_rvalid_i),
      .i_push        (w_push),
      .i_pop         (w_pop),
      .i_full        (w_fifo_full)
   );

   assign imem_req_o    = w_req;
   assign imem_addr_o   = r_fetch_pc;
   assign curr_pc_o     = r_fetch_pc;
   assign instr_valid_o = !w_fifo_empty;
   assign instr_pc_o    = w_fifo_head[32+XLEN-1:32];
   assign instr_o       = w_fifo_head[31:0];

endmodule : mips_fetch_unit

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a 1-cycle in-order memory model.
module tb_mips_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic [31:0] curr_pc_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          grants   = 0;
   logic        hold_resp;
   logic [31:0] next_fetch;
   logic [31:0] pend[$];

   mips_fetch_unit #(
      .XLEN       (32),
      .RESET_PC   (32'h0000_0000),
      .IBUF_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .curr_pc_o     (curr_pc_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: score the request at the edge, then drive the memory response.
   task automatic step();
      logic        fired;
      logic        rv_seen;
      logic [31:0] faddr;
      fired   = imem_req_o && imem_gnt_i && rst_n;
      rv_seen = imem_rvalid_i;
      faddr   = imem_addr_o;
      if (fired) chk("fetch_addr", 64'(faddr), 64'(next_fetch));
      @(posedge clk);
      #1;
      if (rv_seen && pend.size() > 0) void'(pend.pop_front());
      if (fired) begin
         pend.push_back(faddr);
         next_fetch = next_fetch + 32'd4;
         grants++;
      end
      if (redirect_i) next_fetch = {redirect_pc_i[31:2], 2'b00};
      imem_rvalid_i = !hold_resp && (pend.size() > 0);
      imem_rdata_i  = imem_rvalid_i ? word(pend[0]) : 32'h0000_0000;
   endtask

   task automatic deliver(input logic [31:0] pc);
      int t = 0;
      while (!instr_valid_o && t < 20) begin
         step();
         t++;
      end
      chk("deliver_valid", 64'(instr_valid_o), 64'd1);
      chk("deliver_pc", 64'(instr_pc_o), 64'(pc));
      chk("deliver_instr", 64'(instr_o), 64'(word(pc)));
      step();
   endtask

   task automatic redirect_step(input logic [31:0] target);
      redirect_i    = 1'b1;
      redirect_pc_i = target;
      step();
      redirect_i    = 1'b0;
   endtask

   initial begin
      int g0;
      int t;
      rst_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b0;
      hold_resp = 1'b0; next_fetch = 32'h0;
      #12;
      chk("rst_req", 64'(imem_req_o), 64'd0);
      chk("rst_valid", 64'(instr_valid_o), 64'd0);
      chk("rst_instr", 64'(instr_o), 64'd0);
      chk("rst_instr_pc", 64'(instr_pc_o), 64'd0);
      chk("rst_curr_pc", 64'(curr_pc_o), 64'd0);

      // Streaming with always-grant, 1-cycle memory and ready=1.
      @(negedge clk);
      rst_n = 1'b1; imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      step();
      chk("hold_exit_req", 64'(imem_req_o), 64'd1);
      chk("first_addr", 64'(imem_addr_o), 64'd0);
      step();
      chk("no_valid_yet", 64'(instr_valid_o), 64'd0);
      step();
      for (int k = 0; k < 6; k++) begin
         chk("stream_valid", 64'(instr_valid_o), 64'd1);
         chk("stream_pc", 64'(instr_pc_o), 64'(32'(4 * k)));
         chk("stream_instr", 64'(instr_o), 64'(word(32'(4 * k))));
         step();
      end

      // Decode stall: the buffer fills up and requests stop.
      instr_ready_i = 1'b0;
      g0 = grants;
      repeat (10) step();
      chk("stall_grants", 64'(grants - g0), 64'd2);
      chk("stall_req", 64'(imem_req_o), 64'd0);
      chk("stall_valid", 64'(instr_valid_o), 64'd1);
      chk("stall_head_pc", 64'(instr_pc_o), 64'h18);
      chk("stall_head_instr", 64'(instr_o), 64'(word(32'h18)));
      instr_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) deliver(32'h18 + 32'(4 * k));

      // Redirect with two requests outstanding and one word buffered.
      imem_gnt_i = 1'b0;
      repeat (8) step();
      chk("quiet_valid", 64'(instr_valid_o), 64'd0);
      instr_ready_i = 1'b0; imem_gnt_i = 1'b1; hold_resp = 1'b1;
      g0 = grants;
      step();
      hold_resp = 1'b0;
      step();
      hold_resp = 1'b1;
      step();
      chk("pre_redir_grants", 64'(grants - g0), 64'd3);
      chk("pre_redir_valid", 64'(instr_valid_o), 64'd1);
      chk("pre_redir_pc", 64'(instr_pc_o), 64'(next_fetch - 32'd12));
      imem_gnt_i = 1'b0; hold_resp = 1'b0;
      redirect_step(32'h0000_0103);
      chk("redir_flush", 64'(instr_valid_o), 64'd0);
      chk("redir_curr_pc", 64'(curr_pc_o), 64'h100);
      instr_ready_i = 1'b1; imem_gnt_i = 1'b1;
      deliver(32'h100);
      deliver(32'h104);

      // Redirect coinciding with a grant and a response.
      t = 0;
      while (!(imem_rvalid_i && imem_req_o) && t < 20) begin
         step();
         t++;
      end
      chk("coincide_setup", 64'(imem_rvalid_i && imem_req_o), 64'd1);
      redirect_step(32'h0000_2000);
      chk("coincide_flush", 64'(instr_valid_o), 64'd0);
      chk("coincide_curr_pc", 64'(curr_pc_o), 64'h2000);
      deliver(32'h2000);
      deliver(32'h2004);

      // Fetch PC wraps from the top of the address space to zero.
      redirect_step(32'hFFFF_FFF9);
      chk("wrap_curr_pc", 64'(curr_pc_o), 64'hFFFF_FFF8);
      deliver(32'hFFFF_FFF8);
      deliver(32'hFFFF_FFFC);
      deliver(32'h0000_0000);
      deliver(32'h0000_0004);

      // Asynchronous reset with three requests outstanding.
      imem_gnt_i = 1'b0;
      repeat (8) step();
      imem_gnt_i = 1'b1; hold_resp = 1'b1;
      g0 = grants;
      repeat (3) step();
      chk("pre_reset_grants", 64'(grants - g0), 64'd3);
      rst_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      #1;
      chk("areset_req", 64'(imem_req_o), 64'd0);
      chk("areset_valid", 64'(instr_valid_o), 64'd0);
      chk("areset_instr", 64'(instr_o), 64'd0);
      chk("areset_instr_pc", 64'(instr_pc_o), 64'd0);
      chk("areset_curr_pc", 64'(curr_pc_o), 64'd0);
      pend.delete();
      hold_resp = 1'b0; next_fetch = 32'h0;
      @(negedge clk);
      rst_n = 1'b1; imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      deliver(32'h0);
      deliver(32'h4);
      deliver(32'h8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mips_fetch_unit
